// File: rtl/trail_stack_pkg.sv
// -----------------------------------------------------------------------------
// sat_trail_pkg
// Shared types and width helpers for the trail stack slice.
//   trail_state_e : backtrack engine state (IDLE / UNWIND / DONE)
//   cnt_width()   : width of an occupancy counter able to hold 0..DEPTH
//   lvl_width()   : width of a decision level able to hold 0..MAX_LEVEL
//   addr_width()  : width of a storage address for DEPTH entries
//   CNT_W, LVL_W  : the widths for the default geometry (1024 x level 255)
// -----------------------------------------------------------------------------
package sat_trail_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      UNWIND = 2'd1,
      DONE   = 2'd2
   } trail_state_e;

   function automatic int cnt_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

   function automatic int lvl_width(input int max_level);
      return $clog2(max_level + 1);
   endfunction

   function automatic int addr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   localparam int CNT_W = cnt_width(1024);
   localparam int LVL_W = lvl_width(255);

endpackage

// File: rtl/trail_stack_if.sv
// -----------------------------------------------------------------------------
// trail_stack_if
// Bundles every non-clock signal of the trail stack.
//   master : push port, backtrack request, unwind consumer ready, clear
//            (drives) and all status / unwind outputs (observes)
//   slave  : the trail stack itself
// -----------------------------------------------------------------------------
interface trail_stack_if #(
   parameter int WIDTH     = 32,
   parameter int DEPTH     = 1024,
   parameter int MAX_LEVEL = 255
);
   import sat_trail_pkg::*;

   localparam int CW = cnt_width(DEPTH);
   localparam int LW = lvl_width(MAX_LEVEL);

   logic             push_valid;
   logic             push_decision;
   logic [WIDTH-1:0] push_data;
   logic             push_ready;
   logic             bt_start;
   logic [LW-1:0]    bt_level;
   logic             bt_busy;
   logic             bt_done;
   logic             out_valid;
   logic [WIDTH-1:0] out_data;
   logic             out_ready;
   logic [WIDTH-1:0] top_data;
   logic [CW-1:0]    count;
   logic [LW-1:0]    level;
   logic             full;
   logic             empty;
   logic             overflow;
   logic             clear;

   modport master (
      output push_valid, push_decision, push_data, bt_start, bt_level,
             out_ready, clear,
      input  push_ready, bt_busy, bt_done, out_valid, out_data, top_data,
             count, level, full, empty, overflow
   );

   modport slave (
      input  push_valid, push_decision, push_data, bt_start, bt_level,
             out_ready, clear,
      output push_ready, bt_busy, bt_done, out_valid, out_data, top_data,
             count, level, full, empty, overflow
   );

endinterface

// File: rtl/trail_level_table.sv
// -----------------------------------------------------------------------------
// trail_level_table
// Per-level start index table: entry k holds the trail count at the moment
// level k's decision literal was pushed. Entry 0 is never written (the root
// level has no decision), which keeps the index equal to the level.
//   i_we/i_waddr/i_wdata : write port, used on an accepted decision push
//   i_re/i_raddr         : read request, used when a real unwind starts
//   o_rdata              : registered read data, held until the next i_re
// -----------------------------------------------------------------------------
module trail_level_table
   import sat_trail_pkg::*;
#(
   parameter int DEPTH     = 1024,
   parameter int MAX_LEVEL = 255
) (
   input  logic                            clk,
   input  logic                            i_we,
   input  logic [lvl_width(MAX_LEVEL)-1:0] i_waddr,
   input  logic [cnt_width(DEPTH)-1:0]     i_wdata,
   input  logic                            i_re,
   input  logic [lvl_width(MAX_LEVEL)-1:0] i_raddr,
   output logic [cnt_width(DEPTH)-1:0]     o_rdata
);
   localparam int CW = cnt_width(DEPTH);

   logic [CW-1:0] r_table [0:MAX_LEVEL];
   logic [CW-1:0] r_rdata;

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_table[i_waddr] <= i_wdata;
      end
   end

   // The read register doubles as the latched unwind target: it is only
   // loaded when an unwind begins and stays put for the whole unwind.
   always_ff @(posedge clk) begin
      if (i_re) begin
         r_rdata <= r_table[i_raddr];
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/trail_stack.sv
// -----------------------------------------------------------------------------
// trail_stack
// LIFO assignment trail with decision-level tracking and a backtrack engine
// that streams removed entries to the unassign logic.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : trail_stack_if slave (push port, backtrack request, unwind
//                output stream, status flags, synchronous clear)
// -----------------------------------------------------------------------------
module trail_stack
   import sat_trail_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int DEPTH     = 1024,
   parameter int MAX_LEVEL = 255
) (
   input  logic          clk,
   input  logic          rst_n,
   trail_stack_if.slave  bus
);
   localparam int CW = cnt_width(DEPTH);
   localparam int LW = lvl_width(MAX_LEVEL);
   localparam int AW = addr_width(DEPTH);

   trail_state_e     r_state;
   logic [CW-1:0]    r_count;
   logic [LW-1:0]    r_level;
   logic [LW-1:0]    r_bt_level;
   logic             r_overflow;
   logic [WIDTH-1:0] r_mem [DEPTH];

   logic             w_full;
   logic             w_empty;
   logic             w_push_ready;
   logic             w_push_fire;
   logic             w_at_max;
   logic             w_dec_drop;
   logic             w_write;
   logic             w_lvl_we;
   logic [LW-1:0]    w_level_inc;
   logic             w_bt_fire;
   logic             w_bt_unwind;
   logic [CW-1:0]    w_target;
   logic             w_out_valid;
   logic             w_pop;
   logic             w_unwind_end;
   logic [AW-1:0]    w_wr_addr;
   logic [AW-1:0]    w_top_addr;

   assign w_full       = (r_count == CW'(DEPTH));
   assign w_empty      = (r_count == '0);
   assign w_push_ready = (r_state == IDLE) && !w_full;
   assign w_push_fire  = bus.push_valid && w_push_ready;
   assign w_at_max     = (r_level == LW'(MAX_LEVEL));
   // A decision at the deepest level is handshaken but never stored.
   assign w_dec_drop   = w_push_fire && bus.push_decision && w_at_max;
   assign w_write      = w_push_fire && !w_dec_drop;
   assign w_lvl_we     = w_write && bus.push_decision;
   assign w_level_inc  = r_level + LW'(1);

   assign w_bt_fire    = (r_state == IDLE) && bus.bt_start;
   assign w_bt_unwind  = w_bt_fire && (bus.bt_level < r_level);
   assign w_out_valid  = (r_state == UNWIND) && (r_count > w_target);
   assign w_pop        = w_out_valid && bus.out_ready;
   assign w_unwind_end = (r_state == UNWIND) && (r_count == w_target);

   assign w_wr_addr    = AW'(r_count);
   assign w_top_addr   = AW'(r_count - CW'(1));

   // bt_level < level guarantees bt_level+1 is a written, in-range entry.
   trail_level_table #(
      .DEPTH     (DEPTH),
      .MAX_LEVEL (MAX_LEVEL)
   ) u_level_table (
      .clk     (clk),
      .i_we    (w_lvl_we),
      .i_waddr (w_level_inc),
      .i_wdata (r_count),
      .i_re    (w_bt_unwind),
      .i_raddr (bus.bt_level + LW'(1)),
      .o_rdata (w_target)
   );

   always_ff @(posedge clk) begin
      if (w_write) begin
         r_mem[w_wr_addr] <= bus.push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n || bus.clear) begin
         r_state    <= IDLE;
         r_count    <= '0;
         r_level    <= '0;
         r_bt_level <= '0;
         r_overflow <= 1'b0;
      end else begin
         if ((bus.push_valid && w_full) || w_dec_drop) begin
            r_overflow <= 1'b1;
         end
         if (w_write) begin
            r_count <= r_count + CW'(1);
         end
         if (w_lvl_we) begin
            r_level <= w_level_inc;
         end
         case (r_state)
            IDLE: begin
               if (w_bt_fire) begin
                  r_bt_level <= bus.bt_level;
                  r_state    <= w_bt_unwind ? UNWIND : DONE;
               end
            end
            UNWIND: begin
               if (w_pop) begin
                  r_count <= r_count - CW'(1);
               end else if (w_unwind_end) begin
                  r_level <= r_bt_level;
                  r_state <= DONE;
               end
            end
            DONE:    r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.push_ready = w_push_ready;
   assign bus.bt_busy    = (r_state != IDLE);
   assign bus.bt_done    = (r_state == DONE);
   assign bus.out_valid  = w_out_valid;
   assign bus.out_data   = r_mem[w_top_addr];
   assign bus.top_data   = w_empty ? '0 : r_mem[w_top_addr];
   assign bus.count      = r_count;
   assign bus.level      = r_level;
   assign bus.full       = w_full;
   assign bus.empty      = w_empty;
   assign bus.overflow   = r_overflow;

endmodule

// File: tb/tb_trail_stack.sv
// -----------------------------------------------------------------------------
// tb_trail_stack
// Two instances: dut0 with the default geometry for the push/backtrack
// streaming scenarios, dut1 with DEPTH=4 / MAX_LEVEL=2 for the capacity and
// level-limit scenarios. Unwound entries of dut0 are checked against a
// scoreboard queue filled when the backtrack is requested.
// -----------------------------------------------------------------------------
module tb_trail_stack;
   import sat_trail_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   trail_stack_if #(.WIDTH(32), .DEPTH(1024), .MAX_LEVEL(255)) if0 ();
   trail_stack_if #(.WIDTH(32), .DEPTH(4), .MAX_LEVEL(2)) if1 ();

   trail_stack #(.WIDTH(32), .DEPTH(1024), .MAX_LEVEL(255)) dut0 (
      .clk(clk), .rst_n(rst_n), .bus(if0)
   );
   trail_stack #(.WIDTH(32), .DEPTH(4), .MAX_LEVEL(2)) dut1 (
      .clk(clk), .rst_n(rst_n), .bus(if1)
   );

   localparam logic [31:0] A = 32'h0000_00A1, B = 32'h0000_00B2,
                           C = 32'h0000_00C3, D = 32'h0000_00D4,
                           E = 32'h0000_00E5, F = 32'h0000_00F6,
                           G = 32'h0000_0017;

   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0] sb [$];
   logic        stall_prev = 1'b0;
   logic [31:0] held = '0;
   logic [CNT_W-1:0] m_count;
   logic [LVL_W-1:0] m_level;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end else begin
         $display("ok   %s: %0h", tag, got);
      end
   endtask

   // Scoreboard / stability monitor for the dut0 unwind stream.
   always @(negedge clk) begin
      if (rst_n) begin
         if (stall_prev && if0.out_valid)
            chk("out_stable", if0.out_data, held);
         if (if0.out_valid && if0.out_ready) begin
            if (sb.size() == 0) chk("sb_extra", 1, 0);
            else chk("out_data", if0.out_data, sb.pop_front());
         end
         stall_prev = if0.out_valid && !if0.out_ready;
         held       = if0.out_data;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push0(input logic [31:0] data, input logic dec);
      if0.push_valid = 1'b1; if0.push_decision = dec; if0.push_data = data;
      tick();
      if0.push_valid = 1'b0; if0.push_decision = 1'b0;
   endtask

   task automatic push1(input logic [31:0] data, input logic dec);
      if1.push_valid = 1'b1; if1.push_decision = dec; if1.push_data = data;
      tick();
      if1.push_valid = 1'b0; if1.push_decision = 1'b0;
   endtask

   task automatic run_bt(input logic [7:0] lvl, input bit toggle,
                         input int exp_lat, input bit exp_valid);
      int  cyc = 0;
      int  first_valid = -1;
      bit  done = 0;
      bit  pr_bad = 0;
      logic [3:0] pat = 4'b1001;
      if0.bt_level = lvl; if0.bt_start = 1'b1; if0.out_ready = 1'b1;
      while (!done && cyc < 200) begin
         @(posedge clk); #1;
         cyc++;
         if0.bt_start = 1'b0;
         if (toggle) if0.out_ready = pat[cyc % 4];
         @(negedge clk);
         if (if0.out_valid && first_valid < 0) first_valid = cyc;
         if (if0.push_ready) pr_bad = 1;
         if (if0.bt_done) done = 1;
      end
      chk("bt_done_seen", done, 1);
      if (exp_lat >= 0) chk("bt_latency", cyc, exp_lat);
      if (exp_valid) chk("first_valid_cyc", first_valid, 1);
      else           chk("no_out_valid", first_valid, -1);
      chk("push_ready_busy", pr_bad, 0);
      if0.out_ready = 1'b1;
      tick();
      chk("bt_idle", if0.bt_busy, 0);
      chk("sb_drained", sb.size(), 0);
   endtask

   initial begin
      bit saw_done;
      if0.push_valid = 0; if0.push_decision = 0; if0.push_data = '0;
      if0.bt_start = 0; if0.bt_level = '0; if0.out_ready = 1; if0.clear = 0;
      if1.push_valid = 0; if1.push_decision = 0; if1.push_data = '0;
      if1.bt_start = 0; if1.bt_level = '0; if1.out_ready = 1; if1.clear = 0;
      repeat (3) tick();
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_count", if0.count, 0);
      chk("rst_empty", if0.empty, 1);
      chk("rst_level", if0.level, 0);
      chk("rst_ovf", if0.overflow, 0);
      chk("rst_busy", if0.bt_busy, 0);
      chk("rst_outv", if0.out_valid, 0);
      chk("rst_pready", if0.push_ready, 1);
      chk("rst_top", if0.top_data, 0);
      chk("rst1_count", if1.count, 0);
      tick();

      // Three root-level entries.
      push0(A, 0); push0(B, 0); push0(C, 0);
      m_count = 3; m_level = 0;
      chk("abc_count", if0.count, m_count);
      chk("abc_top", if0.top_data, C);
      chk("abc_level", if0.level, m_level);
      chk("abc_empty", if0.empty, 0);

      // Two levels, full backtrack to root with ready held high.
      push0(D, 1); push0(E, 0); push0(F, 1); push0(G, 0);
      chk("dg_level", if0.level, 2);
      chk("dg_count", if0.count, 7);
      chk("dg_top", if0.top_data, G);
      sb.push_back(G); sb.push_back(F); sb.push_back(E); sb.push_back(D);
      run_bt(8'd0, 0, 6, 1);
      chk("bt0_count", if0.count, m_count);
      chk("bt0_level", if0.level, m_level);
      chk("bt0_top", if0.top_data, C);

      // Same setup with a stalling consumer.
      push0(D, 1); push0(E, 0); push0(F, 1); push0(G, 0);
      sb.push_back(G); sb.push_back(F); sb.push_back(E); sb.push_back(D);
      run_bt(8'd0, 1, -1, 1);
      chk("tog_count", if0.count, 3);
      chk("tog_level", if0.level, 0);
      chk("tog_top", if0.top_data, C);

      // Target level at or above current level: immediate done.
      push0(D, 1);
      run_bt(8'd2, 0, 1, 0);
      chk("noop_count", if0.count, 4);
      chk("noop_level", if0.level, 1);

      // Partial backtrack from level 2 to level 1.
      push0(E, 0); push0(F, 1); push0(G, 0);
      sb.push_back(G); sb.push_back(F);
      run_bt(8'd1, 0, 4, 1);
      chk("part_count", if0.count, 5);
      chk("part_level", if0.level, 1);
      chk("part_top", if0.top_data, E);

      // Capacity limit on dut1.
      for (int i = 1; i <= 4; i++) push1(32'(i), 0);
      chk("cap_full", if1.full, 1);
      chk("cap_count", if1.count, 4);
      chk("cap_ovf_pre", if1.overflow, 0);
      push1(32'd5, 0);
      chk("cap_count5", if1.count, 4);
      chk("cap_ovf", if1.overflow, 1);
      chk("cap_top", if1.top_data, 4);
      repeat (3) tick();
      chk("cap_ovf_sticky", if1.overflow, 1);
      if1.clear = 1'b1; tick(); if1.clear = 1'b0;
      chk("clr_count", if1.count, 0);
      chk("clr_ovf", if1.overflow, 0);
      chk("clr_empty", if1.empty, 1);

      // Level limit on dut1.
      push1(32'h11, 1); push1(32'h22, 1); push1(32'h33, 1);
      chk("lvl_level", if1.level, 2);
      chk("lvl_count", if1.count, 2);
      chk("lvl_ovf", if1.overflow, 1);
      push1(32'h44, 0);
      chk("lvl_count2", if1.count, 3);

      // Clear while unwinding with the consumer stalled.
      if1.out_ready = 1'b0; if1.bt_level = '0; if1.bt_start = 1'b1;
      tick(); if1.bt_start = 1'b0;
      chk("mid_busy", if1.bt_busy, 1);
      chk("mid_outv", if1.out_valid, 1);
      chk("mid_data", if1.out_data, 32'h44);
      if1.clear = 1'b1; tick(); if1.clear = 1'b0;
      chk("mclr_busy", if1.bt_busy, 0);
      chk("mclr_count", if1.count, 0);
      chk("mclr_level", if1.level, 0);
      chk("mclr_outv", if1.out_valid, 0);
      saw_done = 0;
      for (int i = 0; i < 4; i++) begin
         if (if1.bt_done) saw_done = 1;
         tick();
      end
      chk("mclr_no_done", saw_done, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
